// File: rtl/di_lut_loader_pkg.sv
// Shared definitions for the DI lookup-table loader.
//   - TERM_* : DI terminal identifiers that commonly receive generated tables
//   - DI_STATUS_OK : responder transfer_status value meaning "accepted"
//   - DI_TERM_DESELECT : terminal address that selects no terminal
//   - di_err_e : error codes reported on err_code
//   - di_lut_state_e : loader sequencer states
package di_lut_loader_pkg;

    localparam logic [15:0] TERM_LookupMap   = 16'h0010;
    localparam logic [15:0] TERM_GammaMap    = 16'h0011;
    localparam logic [15:0] TERM_ContrastMap = 16'h0012;

    localparam logic [15:0] DI_STATUS_OK     = 16'h0000;
    localparam logic [15:0] DI_TERM_DESELECT = 16'hFFFF;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_STATUS  = 2'd2,
        ERR_VERIFY  = 2'd3
    } di_err_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_WAIT,
        ST_WR_STROBE,
        ST_RD_SETUP,
        ST_RD_WAIT,
        ST_RD_SETTLE,
        ST_RD_CHECK,
        ST_FINISH,
        ST_FAIL
    } di_lut_state_e;

endpackage

// File: rtl/lut_curve_gen.sv
// Piecewise-linear curve generator: value = min(2^PIXEL_WIDTH-1, offset + (acc >> GAIN_FRAC)),
// where acc starts at 0 on clear and grows by gain on every step.
// Ports:
//   di_clk  : clock
//   clear   : restart the curve at entry 0 (wins over step)
//   step    : advance to the next entry
//   gain    : unsigned slope with GAIN_FRAC fraction bits
//   offset  : curve intercept
//   value   : clamped table entry for the current position
module lut_curve_gen
    import di_lut_loader_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int GAIN_FRAC   = 8
) (
    input  logic                   di_clk,
    input  logic                   clear,
    input  logic                   step,
    input  logic [15:0]            gain,
    input  logic [PIXEL_WIDTH-1:0] offset,
    output logic [PIXEL_WIDTH-1:0] value
);

    localparam int ACC_W = ADDR_WIDTH + 16;
    // One extra bit so offset + integer part can never wrap before the clamp.
    localparam int SUM_W = ACC_W + 1;

    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] sum;

    function automatic logic [PIXEL_WIDTH-1:0] sat_pixel(input logic [SUM_W-1:0] s);
        if (s > SUM_W'({PIXEL_WIDTH{1'b1}}))
            sat_pixel = {PIXEL_WIDTH{1'b1}};
        else
            sat_pixel = s[PIXEL_WIDTH-1:0];
    endfunction

    // Accumulator is pure data: every pass starts with clear, so no reset needed.
    always_ff @(posedge di_clk) begin
        if (clear)
            acc <= '0;
        else if (step)
            acc <= acc + ACC_W'(gain);
    end

    assign sum   = SUM_W'(offset) + SUM_W'(acc >> GAIN_FRAC);
    assign value = sat_pixel(sum);

endmodule

// File: rtl/di_lut_loader.sv
// DI-bus initiator that writes a generated piecewise-linear curve into a
// terminal's table (one entry per register address) and optionally reads
// every entry back and compares it with the regenerated curve.
// Ports:
//   di_clk, resetb           : clock, asynchronous active-low reset
//   start                    : one-cycle pulse to begin a load (ignored while busy)
//   verify_en, term_addr, base_addr, count, gain, offset : load setup, sampled at start
//   busy, done               : load in progress / one-cycle completion pulse
//   error, err_code, err_index : sticky failure flag, cause and failing entry
//   di_term_addr, di_reg_addr, di_reg_datai : DI address/data towards the responder
//   di_write_mode, di_write, di_read_mode, di_read_req, di_read : DI strobes
//   di_write_rdy, di_read_rdy, di_reg_datao, di_transfer_status : responder side
module di_lut_loader
    import di_lut_loader_pkg::*;
#(
    parameter int PIXEL_WIDTH   = 8,
    parameter int DI_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH    = 10,
    parameter int GAIN_FRAC     = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic                     di_clk,
    input  logic                     resetb,
    input  logic                     start,
    input  logic                     verify_en,
    input  logic [15:0]              term_addr,
    input  logic [31:0]              base_addr,
    input  logic [ADDR_WIDTH:0]      count,
    input  logic [15:0]              gain,
    input  logic [PIXEL_WIDTH-1:0]   offset,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [1:0]               err_code,
    output logic [ADDR_WIDTH-1:0]    err_index,
    output logic [15:0]              di_term_addr,
    output logic [31:0]              di_reg_addr,
    output logic                     di_write_mode,
    output logic                     di_write,
    output logic                     di_read_mode,
    output logic                     di_read_req,
    output logic                     di_read,
    output logic [DI_DATA_WIDTH-1:0] di_reg_datai,
    input  logic                     di_write_rdy,
    input  logic                     di_read_rdy,
    input  logic [DI_DATA_WIDTH-1:0] di_reg_datao,
    input  logic [15:0]              di_transfer_status
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    di_lut_state_e state;

    // Setup captured at start
    logic [15:0]            term_q;
    logic [31:0]            base_q;
    logic [ADDR_WIDTH:0]    count_q;
    logic [15:0]            gain_q;
    logic [PIXEL_WIDTH-1:0] offset_q;
    logic                   verify_q;

    // Entry index needs ADDR_WIDTH+1 bits so a full 2^ADDR_WIDTH table is reachable
    logic [ADDR_WIDTH:0]    idx;
    logic [TW-1:0]          tmr;
    // Still true while every WR_WAIT cycle so far saw ready with a bad status
    logic                   st_bad;

    logic                   last_entry;
    logic                   gen_clear;
    logic                   gen_step;
    logic [PIXEL_WIDTH-1:0] curve_value;
    logic [PIXEL_WIDTH-1:0] rd_data;
    logic                   unused_datao_hi;

    assign last_entry = (idx == count_q - {{ADDR_WIDTH{1'b0}}, 1'b1});
    assign rd_data    = di_reg_datao[PIXEL_WIDTH-1:0];
    assign unused_datao_hi = ^di_reg_datao[DI_DATA_WIDTH-1:PIXEL_WIDTH];

    // The generator must already hold value(i) when a SETUP state reads it, so
    // clear/step are decoded from the current state rather than registered.
    assign gen_clear = ((state == ST_IDLE) && start) ||
                       ((state == ST_WR_STROBE) && last_entry && verify_q);
    assign gen_step  = ((state == ST_WR_STROBE) && !last_entry) ||
                       ((state == ST_RD_CHECK) && !last_entry);

    lut_curve_gen #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .GAIN_FRAC   (GAIN_FRAC)
    ) u_curve (
        .di_clk (di_clk),
        .clear  (gen_clear),
        .step   (gen_step),
        .gain   (gain_q),
        .offset (offset_q),
        .value  (curve_value)
    );

    always_ff @(posedge di_clk) begin
        if ((state == ST_IDLE) && start) begin
            term_q   <= term_addr;
            base_q   <= base_addr;
            count_q  <= count;
            gain_q   <= gain;
            offset_q <= offset;
        end
    end

    always_ff @(posedge di_clk or negedge resetb) begin
        if (!resetb) begin
            state         <= ST_IDLE;
            verify_q      <= 1'b0;
            idx           <= '0;
            tmr           <= '0;
            st_bad        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= ERR_NONE;
            err_index     <= '0;
            di_term_addr  <= DI_TERM_DESELECT;
            di_reg_addr   <= '0;
            di_reg_datai  <= '0;
            di_write_mode <= 1'b0;
            di_write      <= 1'b0;
            di_read_mode  <= 1'b0;
            di_read_req   <= 1'b0;
            di_read       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        verify_q <= verify_en;
                        busy     <= 1'b1;
                        error    <= 1'b0;
                        err_code <= ERR_NONE;
                        idx      <= '0;
                        state    <= (count == '0) ? ST_FINISH : ST_WR_SETUP;
                    end
                end

                ST_WR_SETUP: begin
                    di_term_addr  <= term_q;
                    di_reg_addr   <= base_q + 32'(idx);
                    di_reg_datai  <= DI_DATA_WIDTH'(curve_value);
                    di_write_mode <= 1'b1;
                    tmr           <= '0;
                    st_bad        <= 1'b1;
                    state         <= ST_WR_WAIT;
                end

                ST_WR_WAIT: begin
                    if (di_write_rdy && (di_transfer_status == DI_STATUS_OK)) begin
                        di_write <= 1'b1;
                        state    <= ST_WR_STROBE;
                    end else if (tmr == TMR_LAST) begin
                        err_code <= (st_bad && di_write_rdy) ? ERR_STATUS : ERR_TIMEOUT;
                        state    <= ST_FAIL;
                    end else begin
                        tmr    <= tmr + TW'(1);
                        st_bad <= st_bad && di_write_rdy;
                    end
                end

                ST_WR_STROBE: begin
                    di_write <= 1'b0;
                    if (last_entry) begin
                        if (verify_q) begin
                            idx   <= '0;
                            state <= ST_RD_SETUP;
                        end else begin
                            state <= ST_FINISH;
                        end
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_WR_SETUP;
                    end
                end

                ST_RD_SETUP: begin
                    di_write_mode <= 1'b0;
                    di_read_mode  <= 1'b1;
                    di_read_req   <= 1'b1;
                    di_term_addr  <= term_q;
                    di_reg_addr   <= base_q + 32'(idx);
                    tmr           <= '0;
                    state         <= ST_RD_WAIT;
                end

                ST_RD_WAIT: begin
                    if (di_read_rdy) begin
                        di_read_req <= 1'b0;
                        state       <= ST_RD_SETTLE;
                    end else if (tmr == TMR_LAST) begin
                        err_code <= ERR_TIMEOUT;
                        state    <= ST_FAIL;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                // Responder RAM output is registered: give it one cycle.
                ST_RD_SETTLE: begin
                    di_read <= 1'b1;
                    state   <= ST_RD_CHECK;
                end

                ST_RD_CHECK: begin
                    di_read <= 1'b0;
                    if (rd_data != curve_value) begin
                        err_code <= ERR_VERIFY;
                        state    <= ST_FAIL;
                    end else if (last_entry) begin
                        state <= ST_FINISH;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_RD_SETUP;
                    end
                end

                ST_FAIL: begin
                    error         <= 1'b1;
                    err_index     <= idx[ADDR_WIDTH-1:0];
                    di_write_mode <= 1'b0;
                    di_write      <= 1'b0;
                    di_read_mode  <= 1'b0;
                    di_read_req   <= 1'b0;
                    di_read       <= 1'b0;
                    state         <= ST_FINISH;
                end

                ST_FINISH: begin
                    di_write_mode <= 1'b0;
                    di_write      <= 1'b0;
                    di_read_mode  <= 1'b0;
                    di_read_req   <= 1'b0;
                    di_read       <= 1'b0;
                    di_term_addr  <= DI_TERM_DESELECT;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_di_lut_loader.sv
// Self-checking bench for di_lut_loader with a small DI responder model.
module tb_di_lut_loader;

    logic        di_clk = 1'b0;
    logic        resetb;
    logic        start;
    logic        verify_en;
    logic [15:0] term_addr;
    logic [31:0] base_addr;
    logic [10:0] count;
    logic [15:0] gain;
    logic [7:0]  offset;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [9:0]  err_index;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic        di_write_mode, di_write, di_read_mode, di_read_req, di_read;
    logic [15:0] di_reg_datai;
    logic        di_write_rdy = 1'b0;
    logic        di_read_rdy = 1'b0;
    logic [15:0] di_reg_datao = 16'h0;
    logic [15:0] di_transfer_status = 16'h0;

    always #5 di_clk = ~di_clk;

    di_lut_loader dut (
        .di_clk             (di_clk),
        .resetb             (resetb),
        .start              (start),
        .verify_en          (verify_en),
        .term_addr          (term_addr),
        .base_addr          (base_addr),
        .count              (count),
        .gain               (gain),
        .offset             (offset),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .err_code           (err_code),
        .err_index          (err_index),
        .di_term_addr       (di_term_addr),
        .di_reg_addr        (di_reg_addr),
        .di_write_mode      (di_write_mode),
        .di_write           (di_write),
        .di_read_mode       (di_read_mode),
        .di_read_req        (di_read_req),
        .di_read            (di_read),
        .di_reg_datai       (di_reg_datai),
        .di_write_rdy       (di_write_rdy),
        .di_read_rdy        (di_read_rdy),
        .di_reg_datao       (di_reg_datao),
        .di_transfer_status (di_transfer_status)
    );

    // Responder model: 0 = normal, 1 = never ready, 2 = ready with bad status
    int          rsp_mode = 0;
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = 32'h0;
    bit          mem_clr = 1'b0;
    logic [15:0] mem [0:1023];
    int          wr_cnt = 0, done_cnt = 0, act_cnt = 0, viol_cnt = 0;
    logic        prev_write = 1'b0;

    always @(posedge di_clk) begin
        di_write_rdy       <= (rsp_mode == 0) ? di_write_mode : (rsp_mode == 2);
        di_transfer_status <= (rsp_mode == 2) ? 16'hFFFF : 16'h0000;
        di_read_rdy        <= di_read_req;
        di_reg_datao       <= mem[di_reg_addr[9:0]];
        if (mem_clr) begin
            for (int a = 0; a < 1024; a++) mem[a] <= 16'hDEAD;
        end else if (di_write) begin
            mem[di_reg_addr[9:0]] <= (corrupt_en && di_reg_addr == corrupt_addr) ?
                                     (di_reg_datai ^ 16'h0001) : di_reg_datai;
        end
        if (di_write) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (di_write || di_read || di_write_mode || di_read_mode || di_read_req)
            act_cnt <= act_cnt + 1;
        if ((di_write && di_read) || (di_write && prev_write) ||
            (di_write && !di_write_mode) || (di_read && !di_read_mode) ||
            ((di_write || di_read) && di_write_mode && di_read_mode))
            viol_cnt <= viol_cnt + 1;
        prev_write <= di_write;
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge di_clk);
        #1;
    endtask

    task automatic clear_mem();
        mem_clr = 1'b1;
        tick();
        mem_clr = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int k = 0; k < limit; k++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    task automatic setup(input int cnt, input logic [15:0] g, input logic [7:0] o,
                         input logic [31:0] b, input bit v);
        count     = cnt[10:0];
        gain      = g;
        offset    = o;
        base_addr = b;
        verify_en = v;
        term_addr = 16'h0010;
    endtask

    typedef struct {
        int          cnt;
        logic [15:0] gain;
        logic [7:0]  off;
        logic [31:0] base;
        bit          verify;
        bit          corrupt;
        logic [31:0] caddr;
        logic [9:0]  p0, p1, p2;
        logic [7:0]  e0, e1, e2;
        logic [1:0]  err;
        logic [9:0]  eidx;
        int          writes;
    } vec_t;

    vec_t vecs [7];

    initial begin
        bit ok;
        int cyc, wb, db, ab;

        vecs[0] = '{4,    16'h0100, 8'd10,  32'h0, 1'b0, 1'b0, 32'h0, 10'd0,  10'd3,  10'd1,    8'd10,  8'd13,  8'd11,  2'd0, 10'd0, 4};
        vecs[1] = '{1024, 16'h0100, 8'd200, 32'h0, 1'b0, 1'b0, 32'h0, 10'd54, 10'd55, 10'd1023, 8'd254, 8'd255, 8'd255, 2'd0, 10'd0, 1024};
        vecs[2] = '{16,   16'h0180, 8'd0,   32'h0, 1'b1, 1'b0, 32'h0, 10'd3,  10'd5,  10'd15,   8'd4,   8'd7,   8'd22,  2'd0, 10'd0, 16};
        vecs[3] = '{16,   16'h0100, 8'd0,   32'h0, 1'b1, 1'b1, 32'h7, 10'd7,  10'd0,  10'd6,    8'd6,   8'd0,   8'd6,   2'd3, 10'd7, 16};
        vecs[4] = '{3,    16'h0040, 8'd5,   32'h0, 1'b0, 1'b0, 32'h0, 10'd0,  10'd1,  10'd2,    8'd5,   8'd5,   8'd5,   2'd0, 10'd0, 3};
        vecs[5] = '{2,    16'hFFFF, 8'd1,   32'h0, 1'b0, 1'b0, 32'h0, 10'd0,  10'd1,  10'd1,    8'd1,   8'd255, 8'd255, 2'd0, 10'd0, 2};
        vecs[6] = '{4,    16'h0100, 8'd10,  32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0, 10'h3FE, 10'h3FF, 10'd1, 8'd10, 8'd11, 8'd13, 2'd0, 10'd0, 4};

        resetb = 1'b0;
        start  = 1'b0;
        setup(0, 16'h0, 8'h0, 32'h0, 1'b0);
        tick(); tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_err_index", err_index, 0);
        chk("rst_term", di_term_addr, 16'hFFFF);
        chk("rst_reg_addr", di_reg_addr, 0);
        chk("rst_strobes", {di_write_mode, di_write, di_read_mode, di_read_req, di_read}, 0);
        chk("rst_datai", di_reg_datai, 0);
        resetb = 1'b1;
        clear_mem();

        // count == 0: done two cycles after start, no DI traffic
        ab = act_cnt;
        setup(0, 16'h0100, 8'd10, 32'h0, 1'b1);
        do_start();
        chk("cnt0_busy", busy, 1);
        chk("cnt0_done_early", done, 0);
        tick();
        chk("cnt0_done", done, 1);
        tick();
        chk("cnt0_done_pulse", done, 0);
        chk("cnt0_activity", act_cnt - ab, 0);

        // Table-driven loads
        for (int r = 0; r < 7; r++) begin
            clear_mem();
            corrupt_en   = vecs[r].corrupt;
            corrupt_addr = vecs[r].caddr;
            wb = wr_cnt;
            db = done_cnt;
            setup(vecs[r].cnt, vecs[r].gain, vecs[r].off, vecs[r].base, vecs[r].verify);
            do_start();
            wait_done(10000, ok, cyc);
            chk($sformatf("v%0d_done_seen", r), ok, 1);
            chk($sformatf("v%0d_busy_at_done", r), busy, 0);
            chk($sformatf("v%0d_err_code", r), err_code, vecs[r].err);
            chk($sformatf("v%0d_error", r), error, (vecs[r].err != 2'd0));
            if (vecs[r].err != 2'd0)
                chk($sformatf("v%0d_err_index", r), err_index, vecs[r].eidx);
            tick();
            chk($sformatf("v%0d_done_pulse", r), done, 0);
            chk($sformatf("v%0d_done_count", r), done_cnt - db, 1);
            chk($sformatf("v%0d_writes", r), wr_cnt - wb, vecs[r].writes);
            chk($sformatf("v%0d_probe0", r), mem[vecs[r].p0], {8'h00, vecs[r].e0});
            chk($sformatf("v%0d_probe1", r), mem[vecs[r].p1], {8'h00, vecs[r].e1});
            chk($sformatf("v%0d_probe2", r), mem[vecs[r].p2], {8'h00, vecs[r].e2});
            chk($sformatf("v%0d_term_deselect", r), di_term_addr, 16'hFFFF);
        end
        corrupt_en = 1'b0;

        // Responder never ready: timeout on entry 0
        rsp_mode = 1;
        wb = wr_cnt;
        setup(4, 16'h0100, 8'd10, 32'h0, 1'b0);
        do_start();
        wait_done(2000, ok, cyc);
        chk("to_done_seen", ok, 1);
        chk("to_waited", (cyc >= 255), 1);
        chk("to_err_code", err_code, 1);
        chk("to_err_index", err_index, 0);
        chk("to_error", error, 1);
        chk("to_strobes", {di_write_mode, di_write, di_read_mode, di_read_req, di_read}, 0);
        chk("to_writes", wr_cnt - wb, 0);
        tick();

        // Ready but nonzero status: never strobes, status error
        rsp_mode = 2;
        wb = wr_cnt;
        do_start();
        wait_done(2000, ok, cyc);
        chk("st_done_seen", ok, 1);
        chk("st_err_code", err_code, 2);
        chk("st_error", error, 1);
        chk("st_writes", wr_cnt - wb, 0);
        tick();
        rsp_mode = 0;
        tick(); tick();

        // Next start clears the sticky error
        setup(0, 16'h0, 8'h0, 32'h0, 1'b0);
        do_start();
        chk("clr_error", error, 0);
        chk("clr_err_code", err_code, 0);
        tick(); tick();

        // start while busy is ignored
        clear_mem();
        wb = wr_cnt;
        db = done_cnt;
        setup(4, 16'h0100, 8'd10, 32'h0, 1'b0);
        do_start();
        tick(); tick(); tick();
        setup(2, 16'h0200, 8'd100, 32'h0, 1'b0);
        do_start();
        wait_done(2000, ok, cyc);
        chk("bz_done_seen", ok, 1);
        for (int k = 0; k < 6; k++) tick();
        chk("bz_done_count", done_cnt - db, 1);
        chk("bz_writes", wr_cnt - wb, 4);
        chk("bz_mem3", mem[3], 16'd13);

        // Asynchronous reset in the middle of a long write pass
        setup(1024, 16'h0100, 8'd200, 32'h0, 1'b0);
        do_start();
        for (int k = 0; k < 20; k++) tick();
        chk("ar_busy_before", busy, 1);
        chk("ar_wmode_before", di_write_mode, 1);
        #2 resetb = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_strobes", {di_write_mode, di_write, di_read_mode, di_read_req, di_read}, 0);
        chk("ar_term", di_term_addr, 16'hFFFF);
        chk("ar_reg_addr", di_reg_addr, 0);
        chk("ar_datai", di_reg_datai, 0);
        tick();
        resetb = 1'b1;
        tick(); tick();
        chk("ar_idle_busy", busy, 0);

        chk("strobe_rule", viol_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/di_lut_loader.md
Name: di_lut_loader

Overview:
- DI-bus initiator. Generates a piecewise-linear lookup curve and writes it into a DI terminal's table, e.g. TERM_LookupMap, one word per register address.
- Optional read-back pass re-reads every entry and compares it against the regenerated curve.
- Sits in the di_clk domain between the host/sequencer and the DI responder terminals; frees the host from streaming 1024 table words.

Parameters:
- PIXEL_WIDTH, 8, table entry width; max entry value is 2^PIXEL_WIDTH-1.
- DI_DATA_WIDTH, 16, DI data bus width; entries are zero-extended.
- ADDR_WIDTH, 10, table index width; max count is 2^ADDR_WIDTH.
- GAIN_FRAC, 8, fractional bits of gain.
- TIMEOUT, 255, di_clk cycles to wait for a ready before an error is raised.

Ports:
- di_clk  in  1  DI clock.
- resetb  in  1  async active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored while busy.
- verify_en  in  1  sampled at start; enables the read-back pass.
- term_addr  in  16  target terminal; sampled at start.
- base_addr  in  32  first register address; sampled at start.
- count  in  ADDR_WIDTH+1  number of entries, 0..2^ADDR_WIDTH; sampled at start.
- gain  in  16  slope, unsigned, GAIN_FRAC fraction bits; sampled at start.
- offset  in  PIXEL_WIDTH  curve intercept; sampled at start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky; cleared by the next start.
- err_code  out  2  0 none, 1 timeout, 2 nonzero transfer_status, 3 verify mismatch.
- err_index  out  ADDR_WIDTH  index of the failing entry.
- di_term_addr  out  16  DI terminal address.
- di_reg_addr  out  32  DI register address.
- di_write_mode, di_write, di_read_mode, di_read_req, di_read  out  1 each  DI strobes.
- di_reg_datai  out  DI_DATA_WIDTH  write data.
- di_write_rdy, di_read_rdy  in  1 each  responder readies.
- di_reg_datao  in  DI_DATA_WIDTH  read data.
- di_transfer_status  in  16  responder status; 0 means OK.

Behaviour:
- Reset:
  - All outputs 0 and state IDLE.
  - di_term_addr resets to 16'hFFFF so no terminal is selected.
- Curve generation:
  - Accumulator acc is ADDR_WIDTH+16 bits; acc=0 at entry 0, then acc += gain per entry.
  - value(i) = min(2^PIXEL_WIDTH-1, offset + (acc >> GAIN_FRAC)).
  - The sum is computed wide so it never wraps.
  - The read-back pass resets acc to 0 and regenerates identically; no multiplier.
- FSM states: IDLE, WR_SETUP, WR_WAIT, WR_STROBE, RD_SETUP, RD_WAIT, RD_SETTLE, RD_CHECK, FINISH, FAIL.
- IDLE:
  - On start, latch all inputs, clear error/err_code, and assert busy.
  - count==0: go to FINISH, giving done 2 cycles after start with no DI activity.
  - Otherwise go to WR_SETUP.
- Write pass:
  - WR_SETUP: drive di_term_addr, di_reg_addr=base+i, di_reg_datai=value(i), di_write_mode=1.
  - WR_WAIT: wait for di_write_rdy=1 AND di_transfer_status==0.
  - WR_STROBE: di_write=1 for exactly one cycle.
  - Address, data and mode stay stable from WR_SETUP through WR_STROBE.
  - Last entry: go to RD_SETUP if verify is enabled, else FINISH. Otherwise increment i and return to WR_SETUP.
- Read pass:
  - RD_SETUP: di_read_mode=1, di_reg_addr=base+i, di_read_req=1. The request is held until di_read_rdy=1.
  - RD_SETTLE: one extra cycle after di_read_rdy, absorbing the registered RAM output.
  - RD_CHECK: sample di_reg_datao[PIXEL_WIDTH-1:0], pulse di_read for one cycle, and compare against value(i).
  - A mismatch sets err_code=3 and goes to FAIL.
- Timeout:
  - A counter resets on entering each WAIT state.
  - Reaching TIMEOUT cycles gives err_code=1 and FAIL.
  - In WR_WAIT, if di_write_rdy=1 but di_transfer_status!=0 for TIMEOUT cycles, err_code=2 instead.
- Completion:
  - FAIL: set error, record err_index=i, then FINISH.
  - FINISH: all DI strobes and modes deasserted, di_term_addr=16'hFFFF, done=1 for one cycle, busy=0, back to IDLE.
- Edge cases:
  - start while busy is ignored.
  - Async reset mid-transfer aborts immediately: no partial strobes, outputs return to reset values.
  - di_reg_addr wraps modulo 2^32.
  - count==2^ADDR_WIDTH writes every entry; i is ADDR_WIDTH+1 bits internally.
- Strobe rule: at most one of di_write/di_read per cycle, and never with both modes high.

Decomposition:
- Shared package/defines:
  - TERM_* terminal ids.
  - DI status OK code (16'h0000).
  - err_code enumeration.
  - Deselect address 16'hFFFF.
- Sub-module lut_curve_gen: accumulator + clamp. Has clear, step and value outputs; reused by the write and read passes.

Test Plan:
- Write-only, count=4, gain=0x0100, offset=10, base=0, responder model with 1-cycle write_rdy -> writes 10,11,12,13 to addrs 0..3; done exactly once; error=0.
- Clamp: PIXEL_WIDTH=8, count=1024, gain=0x0100, offset=200 -> entry 55=255, entry 1023=255, entry 54=254.
- Verify pass, with the responder model corrupting entry 7 -> err_code=3, err_index=7, error=1, done pulses.
- Responder never raises di_write_rdy -> after 255 cycles err_code=1, err_index=0, all DI strobes low.
- Responder with di_transfer_status=16'hFFFF and write_rdy=1 -> no di_write pulse ever; err_code=2 after TIMEOUT.
- Edge cases:
  - count=0 -> done 2 cycles after start, no DI activity.
  - resetb asserted mid-write -> outputs return to reset values immediately.
  - start while busy -> ignored.
